// File: rtl/math_sin_rr_scheduler.sv
// math_sin_rr_scheduler: round-robin sharing of one external math_sin across requesters with tagged fixed-latency return
module math_sin_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [NUM_REQ*WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0]         sin_a,
  input  logic [WIDTH-1:0]         sin_result,
  output logic                     busy
);
  localparam int PW = $clog2(NUM_REQ);
  if (!((WIDTH == 32 || WIDTH == 64) && NUM_REQ >= 2 && LATENCY >= 2)) begin : g_bad_param
    $fatal(1, "math_sin_rr_scheduler: illegal WIDTH/NUM_REQ/LATENCY");
  end
  logic [NUM_REQ-1:0]            pending_q, rv_q, elig, gnt;
  logic [NUM_REQ-1:0][WIDTH-1:0] rd_q;
  logic [PW-1:0]                 ptr_q, ptr_d, gnt_idx, iss_tag_q, f_tag;
  logic [WIDTH-1:0]              sin_a_q, f_dat;
  logic                          iss_v_q, found, f_v;
  int                            idx;
  assign elig = req_valid & ~pending_q;
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(ptr_q) + o) % NUM_REQ;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    gnt   = (found && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    ptr_d = !found ? ptr_q : (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
  // Zero extra delay stages when LATENCY is 2: the result goes straight into the response buffer.
  if (LATENCY == 2) begin : g_direct
    assign f_v   = iss_v_q;
    assign f_tag = iss_tag_q;
    assign f_dat = sin_result;
  end else begin : g_delay
    logic [LATENCY-3:0]            d_v_q;
    logic [LATENCY-3:0][PW-1:0]    d_tag_q;
    logic [LATENCY-3:0][WIDTH-1:0] d_dat_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        d_v_q   <= '0;
        d_tag_q <= '0;
        d_dat_q <= '0;
      end else begin
        d_v_q[0]   <= iss_v_q;
        d_tag_q[0] <= iss_tag_q;
        d_dat_q[0] <= sin_result;
        for (int j = 1; j < LATENCY - 2; j++) begin
          d_v_q[j]   <= d_v_q[j-1];
          d_tag_q[j] <= d_tag_q[j-1];
          d_dat_q[j] <= d_dat_q[j-1];
        end
      end
    end
    assign f_v   = d_v_q[LATENCY-3];
    assign f_tag = d_tag_q[LATENCY-3];
    assign f_dat = d_dat_q[LATENCY-3];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rv_q      <= '0;
      rd_q      <= '0;
      ptr_q     <= '0;
      iss_v_q   <= 1'b0;
      iss_tag_q <= '0;
      sin_a_q   <= '0;
    end else begin
      pending_q <= (pending_q | gnt) & ~(rv_q & resp_ready);
      ptr_q     <= ptr_d;
      iss_v_q   <= found;
      if (found) begin
        iss_tag_q <= gnt_idx;
        sin_a_q   <= req_data[gnt_idx*WIDTH +: WIDTH];
      end
      // One outstanding op per requester, so a write never meets a still-full buffer.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (f_v && f_tag == PW'(i)) begin
          rv_q[i] <= 1'b1;
          rd_q[i] <= f_dat;
        end else if (resp_ready[i]) begin
          rv_q[i] <= 1'b0;
        end
      end
    end
  end
  assign req_ready  = gnt;
  assign resp_valid = rv_q;
  assign resp_data  = rd_q;
  assign sin_a      = sin_a_q;
  assign busy       = |pending_q;
endmodule

// File: tb/tb_math_sin_rr_scheduler.sv
// tb_math_sin_rr_scheduler: scoreboard-based bench for the shared math_sin round-robin scheduler
module tb_math_sin_rr_scheduler;
  localparam int W = 32, N = 4, L = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '1;
  logic [N*W-1:0] req_data = '0, resp_data;
  logic [W-1:0]   sin_a, sin_result;
  logic           busy;
  logic [N-1:0]   b_req_valid = '0, b_req_ready, b_resp_valid, b_resp_ready = '1;
  logic [N*64-1:0] b_req_data = '0, b_resp_data;
  logic [63:0]    b_sin_a, b_sin_result;
  logic           b_busy;
  function automatic logic [31:0] fsin(input logic [31:0] x);
    return (x == 32'h3FC90FDB) ? 32'h3F800000 : ({x[30:0], x[31]} ^ 32'h5A5A5A5A);
  endfunction
  assign sin_result   = fsin(sin_a);
  assign b_sin_result = {b_sin_a[62:0], b_sin_a[63]};
  math_sin_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sin_a(sin_a), .sin_result(sin_result), .busy(busy));
  math_sin_rr_scheduler #(.WIDTH(64), .NUM_REQ(N), .LATENCY(4)) dut64 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .sin_a(b_sin_a), .sin_result(b_sin_result), .busy(b_busy));
  int errors = 0, checks = 0, cyc = 0;
  logic [W-1:0] exp_q [N][$];
  int gc_q [N][$];
  int last_g [N];
  int gcnt [N];
  logic [N-1:0] rv_prev = '0, rdy_prev = '0;
  logic [W-1:0] rd_prev [N];
  logic [W-1:0] me;
  int mg;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        gc_q[i].delete();
        last_g[i] = -100;
      end
      rv_prev = '0;
    end else begin
      checks++;
      if ($countones(req_ready) > 1) begin errors++; $display("FAIL onehot: req_ready=%b required at most one bit", req_ready); end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          checks++;
          if (cyc - last_g[i] < L + 1) begin errors++; $display("FAIL regrant%0d: gap=%0d required>=%0d", i, cyc - last_g[i], L + 1); end
          last_g[i] = cyc;
          gcnt[i]++;
          exp_q[i].push_back(fsin(req_data[i*W +: W]));
          gc_q[i].push_back(cyc);
        end
        if (resp_valid[i] && !rv_prev[i]) begin
          checks++;
          if (gc_q[i].size() == 0) begin errors++; $display("FAIL spurious%0d: resp_valid=1 required no response", i); end
          else begin
            mg = gc_q[i].pop_front();
            if (cyc - mg != L) begin errors++; $display("FAIL latency%0d: got=%0d required=%0d", i, cyc - mg, L); end
          end
        end
        if (rv_prev[i] && !rdy_prev[i]) begin
          checks++;
          if (!resp_valid[i] || resp_data[i*W +: W] !== rd_prev[i]) begin
            errors++; $display("FAIL hold%0d: valid=%b data=%h required valid=1 data=%h", i, resp_valid[i], resp_data[i*W +: W], rd_prev[i]);
          end
        end
        if (resp_valid[i] && resp_ready[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin errors++; $display("FAIL extra%0d: data=%h required none", i, resp_data[i*W +: W]); end
          else begin
            me = exp_q[i].pop_front();
            if (resp_data[i*W +: W] !== me) begin errors++; $display("FAIL data%0d: got=%h required=%h", i, resp_data[i*W +: W], me); end
          end
        end
        rd_prev[i] = resp_data[i*W +: W];
      end
      rv_prev  = resp_valid;
      rdy_prev = resp_ready;
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; req_valid = '0; resp_ready = '1;
    next();
    rst = 0;
  endtask
  task automatic drain();
    req_valid = '0; resp_ready = '1;
    repeat (L + 3) next();
  endtask
  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
  endtask
  task automatic test_reset();
    next();
    rst = 1; req_valid = '1; rand_data();
    next();
    @(negedge clk);
    checks += 5;
    if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got=%b required=0", req_ready); end
    if (resp_valid !== '0) begin errors++; $display("FAIL rst_valid: got=%b required=0", resp_valid); end
    if (resp_data !== '0) begin errors++; $display("FAIL rst_data: got=%h required=0", resp_data); end
    if (sin_a !== '0) begin errors++; $display("FAIL rst_sin_a: got=%h required=0", sin_a); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got=%b required=0", busy); end
    next();
    rst = 0; req_valid = '0;
  endtask
  task automatic test_single();
    req_valid = 4'b0001; req_data[31:0] = 32'h3FC90FDB; resp_ready = '1;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got=%b required=0001", req_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0: got=%b required=0", busy); end
    next();
    req_valid = '0;
    @(negedge clk);
    checks += 3;
    if (sin_a !== 32'h3FC90FDB) begin errors++; $display("FAIL single_sin_a: got=%h required=3fc90fdb", sin_a); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got=%b required=1", busy); end
    if (resp_valid !== '0) begin errors++; $display("FAIL single_early: got=%b required=0", resp_valid); end
    @(negedge clk);
    checks += 3;
    if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got=%b required=0001", resp_valid); end
    if (resp_data[31:0] !== 32'h3F800000) begin errors++; $display("FAIL single_data: got=%h required=3f800000", resp_data[31:0]); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy2: got=%b required=1", busy); end
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy3: got=%b required=0", busy); end
    if (resp_valid !== '0) begin errors++; $display("FAIL single_done: got=%b required=0", resp_valid); end
    next();
  endtask
  task automatic test_round_robin();
    do_reset();
    req_valid = '1; rand_data();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== N'(1) << (k % N)) begin errors++; $display("FAIL rr_order%0d: got=%b required=%b", k, req_ready, N'(1) << (k % N)); end
      next();
      rand_data();
    end
    drain();
  endtask
  task automatic test_backpressure();
    int s [N];
    bit seen;
    do_reset();
    for (int i = 0; i < N; i++) s[i] = gcnt[i];
    resp_ready = 4'b1101; req_valid = '1; rand_data();
    repeat (12) begin next(); rand_data(); end
    @(negedge clk);
    checks += 4;
    if (gcnt[1] - s[1] != 1) begin errors++; $display("FAIL bp_req1_grants: got=%0d required=1", gcnt[1] - s[1]); end
    if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_held: got=%b required=1", resp_valid[1]); end
    if (gcnt[0] - s[0] < 3) begin errors++; $display("FAIL bp_req0_progress: got=%0d required>=3", gcnt[0] - s[0]); end
    if (gcnt[3] - s[3] < 3) begin errors++; $display("FAIL bp_req3_progress: got=%0d required>=3", gcnt[3] - s[3]); end
    next();
    resp_ready = '1;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = req_ready[1];
      next();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_release: req1 grant got=0 required=1 within 6 cycles"); end
    drain();
  endtask
  task automatic test_reset_midop();
    do_reset();
    req_valid = 4'b0101; rand_data();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant: got=%b required=0001", req_ready); end
    next();
    rst = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready: got=%b required=0", req_ready); end
    next();
    rst = 0; req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: valid=%b busy=%b required 0 and 0", k, resp_valid, busy); end
      next();
    end
    req_valid = 4'b1100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_regrant: got=%b required=0100", req_ready); end
    next();
    drain();
  endtask
  task automatic test_resp_reissue();
    logic [N-1:0] exp_rdy [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000};
    do_reset();
    req_valid = 4'b1000; rand_data();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy[k]) begin errors++; $display("FAIL reissue_c%0d: req_ready=%b required=%b", k, req_ready, exp_rdy[k]); end
      if (k == 2) begin
        checks++;
        if (resp_valid[3] !== 1'b1) begin errors++; $display("FAIL reissue_resp: resp_valid3=%b required=1", resp_valid[3]); end
      end
      next();
    end
    drain();
  endtask
  task automatic test_wide();
    logic [63:0] vals [2] = '{64'h0, 64'h7FF8000000000001};
    logic [63:0] e;
    for (int v = 0; v < 2; v++) begin
      e = {vals[v][62:0], vals[v][63]};
      b_req_valid = 4'b0100; b_req_data[128 +: 64] = vals[v];
      @(negedge clk);
      checks++;
      if (b_req_ready !== 4'b0100) begin errors++; $display("FAIL wide_grant%0d: got=%b required=0100", v, b_req_ready); end
      next();
      b_req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checks++;
        if (b_resp_valid !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
          errors++; $display("FAIL wide_valid%0d_t%0d: got=%b required=%b", v, k, b_resp_valid, (k == 4) ? 4'b0100 : 4'b0000);
        end
        if (k == 4) begin
          checks++;
          if (b_resp_data[128 +: 64] !== e) begin errors++; $display("FAIL wide_data%0d: got=%h required=%h", v, b_resp_data[128 +: 64], e); end
        end
        next();
      end
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_resp_reissue();
    test_wide();
    drain();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL lost%0d: outstanding=%0d required=0", i, exp_q[i].size()); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
